// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter sending DATA_BYTE bytes per request,
// byte 0 first, with no idle gap between the bytes of one request.
//
// Ports:
//   i_clk                   clock, all state on its rising edge
//   i_rst                   asynchronous active-high reset
//   txEn                    enable; low aborts any frame and holds idle
//   txStart                 single-cycle request, accepted only in idle
//   uart_tx_sended_data     parallel payload, byte 0 is [7:0]
//   uart_tx_taken_data_bit  registered serial line, idle high
//   txBusy                  high while a frame sequence is in progress
//   txDone                  one-cycle pulse after the last stop bit
module uart_tx #(
    parameter int unsigned DATA_BYTE    = 1,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   txEn,
    input  logic                   txStart,
    input  logic [DATA_BYTE*8-1:0] uart_tx_sended_data,
    output logic                   uart_tx_taken_data_bit,
    output logic                   txBusy,
    output logic                   txDone
);

    localparam int unsigned DATA_W     = DATA_BYTE * 8;
    localparam int unsigned CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BYTE_W     = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;
    localparam int unsigned BYTE_SLOTS = 1 << BYTE_W;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(DATA_BYTE - 1);
    localparam logic [2:0]        BIT_LAST  = 3'd7;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state,   stateNext;
    logic [CNT_W-1:0]  baudCnt, baudCntNext;
    logic [2:0]        bitIdx,  bitIdxNext;
    logic [BYTE_W-1:0] byteIdx, byteIdxNext;
    logic [DATA_W-1:0] dataReg, dataRegNext;
    logic              lineNext;
    logic              busyNext;
    logic              doneNext;
    logic              bitEnd;
    logic [7:0]        curByte;
    logic [7:0]        byteSlot [BYTE_SLOTS];

    // Byte view of the latched payload, padded to a power of two so the
    // byte index selects it at its natural width.
    for (genvar g = 0; g < BYTE_SLOTS; g++) begin : gByteSlot
        if (g < DATA_BYTE) begin : gUsed
            assign byteSlot[g] = dataReg[g*8 +: 8];
        end else begin : gPad
            assign byteSlot[g] = 8'h00;
        end
    end

    assign curByte = byteSlot[byteIdx];
    assign bitEnd  = (baudCnt == CNT_LAST);

    // Next-state and next-output logic.
    always_comb begin
        stateNext   = state;
        baudCntNext = baudCnt;
        bitIdxNext  = bitIdx;
        byteIdxNext = byteIdx;
        dataRegNext = dataReg;
        lineNext    = uart_tx_taken_data_bit;
        busyNext    = txBusy;
        doneNext    = 1'b0;

        case (state)
            IDLE: begin
                if (txEn && txStart) begin
                    stateNext   = START;
                    dataRegNext = uart_tx_sended_data;
                    baudCntNext = '0;
                    bitIdxNext  = '0;
                    byteIdxNext = '0;
                    lineNext    = 1'b0;
                    busyNext    = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext   = DATA;
                    baudCntNext = '0;
                    bitIdxNext  = '0;
                    lineNext    = curByte[0];
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudCntNext = '0;
                    if (bitIdx == BIT_LAST) begin
                        stateNext = STOP;
                        lineNext  = 1'b1;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                        lineNext   = curByte[bitIdx + 3'd1];
                    end
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bitEnd) begin
                    baudCntNext = '0;
                    if (byteIdx == BYTE_LAST) begin
                        stateNext = IDLE;
                        lineNext  = 1'b1;
                        busyNext  = 1'b0;
                        doneNext  = 1'b1;
                    end else begin
                        // Next byte's start bit follows the stop bit directly.
                        stateNext   = START;
                        byteIdxNext = byteIdx + BYTE_W'(1);
                        lineNext    = 1'b0;
                    end
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                lineNext  = 1'b1;
                busyNext  = 1'b0;
            end
        endcase

        // Dropping the enable mid-sequence abandons it silently.
        if ((state != IDLE) && !txEn) begin
            stateNext   = IDLE;
            baudCntNext = '0;
            bitIdxNext  = '0;
            byteIdxNext = '0;
            lineNext    = 1'b1;
            busyNext    = 1'b0;
            doneNext    = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                  <= IDLE;
            baudCnt                <= '0;
            bitIdx                 <= '0;
            byteIdx                <= '0;
            dataReg                <= '0;
            uart_tx_taken_data_bit <= 1'b1;
            txBusy                 <= 1'b0;
            txDone                 <= 1'b0;
        end else begin
            state                  <= stateNext;
            baudCnt                <= baudCntNext;
            bitIdx                 <= bitIdxNext;
            byteIdx                <= byteIdxNext;
            dataReg                <= dataRegNext;
            uart_tx_taken_data_bit <= lineNext;
            txBusy                 <= busyNext;
            txDone                 <= doneNext;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Two instances run side by side
// (one and two bytes per request, 4 clocks per bit); a cycle-offset model
// predicts line/busy/done and is compared on every falling edge.
module tb_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en;
    logic [1:0]  start;
    logic [15:0] dataIn [2];
    logic [1:0]  lineO;
    logic [1:0]  busyO;
    logic [1:0]  doneO;

    int total = 0;
    int bad   = 0;

    // Model state: offset in cycles since the accepting edge.
    logic        mAct  [2] = '{1'b0, 1'b0};
    int          mT    [2] = '{0, 0};
    logic [15:0] mPay  [2] = '{16'h0, 16'h0};
    logic        mLine [2] = '{1'b1, 1'b1};
    logic        mBusy [2] = '{1'b0, 1'b0};
    logic        mDone [2] = '{1'b0, 1'b0};

    // Recorders for the hand-computed expectations.
    logic log0 [$];
    logic log1 [$];
    int   busyCyc [2] = '{0, 0};
    int   doneCnt [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_tx #(.DATA_BYTE(1), .CLKS_PER_BIT(CPB)) dut0 (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .txEn                   (en[0]),
        .txStart                (start[0]),
        .uart_tx_sended_data    (dataIn[0][7:0]),
        .uart_tx_taken_data_bit (lineO[0]),
        .txBusy                 (busyO[0]),
        .txDone                 (doneO[0])
    );

    uart_tx #(.DATA_BYTE(2), .CLKS_PER_BIT(CPB)) dut1 (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .txEn                   (en[1]),
        .txStart                (start[1]),
        .uart_tx_sended_data    (dataIn[1]),
        .uart_tx_taken_data_bit (lineO[1]),
        .txBusy                 (busyO[1]),
        .txDone                 (doneO[1])
    );

    // Line value at cycle offset t of a sequence: 10 bits per byte,
    // start 0, data LSB first, stop 1, each held CPB cycles.
    function automatic logic frameBit(logic [15:0] p, int t);
        int bitPos;
        int pos;
        int byteNo;
        logic [15:0] sh;
        bitPos = t / CPB;
        pos    = bitPos % 10;
        byteNo = bitPos / 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        sh = p >> (byteNo * 8 + pos - 1);
        return sh[0];
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model.
    always @(posedge clk or posedge rst) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                mAct[u]  <= 1'b0;
                mT[u]    <= 0;
                mLine[u] <= 1'b1;
                mBusy[u] <= 1'b0;
                mDone[u] <= 1'b0;
            end else begin
                mDone[u] <= 1'b0;
                if (mAct[u]) begin
                    if (!en[u]) begin
                        mAct[u]  <= 1'b0;
                        mLine[u] <= 1'b1;
                        mBusy[u] <= 1'b0;
                    end else if (mT[u] + 1 == (u + 1) * 10 * CPB) begin
                        mAct[u]  <= 1'b0;
                        mLine[u] <= 1'b1;
                        mBusy[u] <= 1'b0;
                        mDone[u] <= 1'b1;
                    end else begin
                        mT[u]    <= mT[u] + 1;
                        mLine[u] <= frameBit(mPay[u], mT[u] + 1);
                    end
                end else if (en[u] && start[u]) begin
                    mAct[u]  <= 1'b1;
                    mT[u]    <= 0;
                    mPay[u]  <= dataIn[u];
                    mBusy[u] <= 1'b1;
                    mLine[u] <= frameBit(dataIn[u], 0);
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus recording.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            check($sformatf("line%0d", u), 32'(lineO[u]), 32'(mLine[u]));
            check($sformatf("busy%0d", u), 32'(busyO[u]), 32'(mBusy[u]));
            check($sformatf("done%0d", u), 32'(doneO[u]), 32'(mDone[u]));
            if (busyO[u] === 1'b1) begin
                busyCyc[u]++;
                if (u == 0) log0.push_back(lineO[u]);
                else        log1.push_back(lineO[u]);
            end
            if (doneO[u] === 1'b1) doneCnt[u]++;
        end
    end

    task automatic clearLogs();
        log0.delete();
        log1.delete();
        busyCyc[0] = 0;
        busyCyc[1] = 0;
        doneCnt[0] = 0;
        doneCnt[1] = 0;
    endtask

    // Called at a falling edge; the request is taken at the next rising edge.
    task automatic sendReq(int u, logic [15:0] d);
        en[u]     = 1'b1;
        start[u]  = 1'b1;
        dataIn[u] = d;
        @(negedge clk);
        start[u]  = 1'b0;
        dataIn[u] = 16'($urandom);
    endtask

    task automatic waitDone(int u, int budget, string nm);
        int c;
        c = 0;
        while (doneO[u] !== 1'b1 && c < budget) begin
            @(negedge clk);
            dataIn[u] = 16'($urandom);
            c++;
        end
        check({nm, "_done_seen"}, 32'(doneO[u]), 32'd1);
    endtask

    // Compares the middle sample of each recorded bit against a literal string.
    task automatic checkLog(int u, string nm, string s);
        int   idx;
        logic v;
        for (int i = 0; i < s.len(); i++) begin
            idx = i * CPB + CPB / 2;
            v   = 1'bx;
            if (u == 0 && idx < log0.size()) v = log0[idx];
            if (u == 1 && idx < log1.size()) v = log1[idx];
            check($sformatf("%s_bit%0d", nm, i), 32'(v), (s[i] == "1") ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        en        = 2'b11;
        start     = 2'b00;
        dataIn[0] = 16'h0;
        dataIn[1] = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_line", 32'(lineO), 32'h3);
        check("rst_busy", 32'(busyO), 32'h0);
        check("rst_done", 32'(doneO), 32'h0);

        // Single byte, accepted at the first edge after reset release.
        rst = 1'b0;
        clearLogs();
        sendReq(0, 16'h00A5);
        check("a5_first_busy", 32'(busyO[0]), 32'd1);
        check("a5_first_line", 32'(lineO[0]), 32'd0);
        waitDone(0, 60, "a5");
        @(negedge clk);
        check("a5_busy_cycles", busyCyc[0], 40);
        check("a5_done_count", doneCnt[0], 1);
        checkLog(0, "a5", "0101001011");

        // Two bytes, 0x81 then 0x3C, no gap.
        clearLogs();
        sendReq(1, 16'h3C81);
        waitDone(1, 100, "mb");
        @(negedge clk);
        check("mb_busy_cycles", busyCyc[1], 80);
        check("mb_done_count", doneCnt[1], 1);
        checkLog(1, "mb", "01000000110001111001");

        // Back-to-back: second request raised in the done cycle.
        clearLogs();
        sendReq(0, 16'h0000);
        waitDone(0, 60, "b2b1");
        sendReq(0, 16'h00FF);
        check("b2b_busy", 32'(busyO[0]), 32'd1);
        check("b2b_line", 32'(lineO[0]), 32'd0);
        waitDone(0, 60, "b2b2");
        @(negedge clk);
        check("b2b_busy_cycles", busyCyc[0], 80);
        check("b2b_done_count", doneCnt[0], 2);
        checkLog(0, "b2b", "00000000010111111111");

        // Request during a frame is ignored.
        clearLogs();
        sendReq(0, 16'h0055);
        repeat (9) @(negedge clk);
        start[0]  = 1'b1;
        dataIn[0] = 16'h00FF;
        @(negedge clk);
        start[0] = 1'b0;
        waitDone(0, 60, "ign");
        @(negedge clk);
        check("ign_busy_cycles", busyCyc[0], 40);
        check("ign_done_count", doneCnt[0], 1);
        checkLog(0, "ign", "0101010101");

        // Request with enable low is ignored.
        clearLogs();
        en[0]    = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("dis_busy_cycles", busyCyc[0], 0);
        check("dis_line", 32'(lineO[0]), 32'd1);
        en[0] = 1'b1;

        // Abort at cycle 17, then immediate restart.
        clearLogs();
        sendReq(1, 16'h1234);
        repeat (16) @(negedge clk);
        en[1] = 1'b0;
        @(negedge clk);
        check("abort_line", 32'(lineO[1]), 32'd1);
        check("abort_busy", 32'(busyO[1]), 32'd0);
        check("abort_done", 32'(doneO[1]), 32'd0);
        sendReq(1, 16'($urandom));
        check("abort_restart_busy", 32'(busyO[1]), 32'd1);
        waitDone(1, 100, "abort");
        @(negedge clk);
        check("abort_done_count", doneCnt[1], 1);
        check("abort_busy_cycles", busyCyc[1], 97);

        // Asynchronous reset between edges at cycle 22.
        clearLogs();
        sendReq(0, 16'h00C3);
        repeat (21) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_line", 32'(lineO[0]), 32'd1);
        check("arst_busy", 32'(busyO[0]), 32'd0);
        check("arst_done", 32'(doneO[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("arst_done_count", doneCnt[0], 0);
        check("arst_busy_cycles", busyCyc[0], 22);
        rst = 1'b0;
        clearLogs();
        sendReq(0, 16'h005A);
        waitDone(0, 60, "5a");
        @(negedge clk);
        check("5a_done_count", doneCnt[0], 1);
        check("5a_busy_cycles", busyCyc[0], 40);
        checkLog(0, "5a", "0010110101");

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                start[u]  = ($urandom_range(0, 9) == 0);
                en[u]     = ($urandom_range(0, 299) != 0);
                dataIn[u] = 16'($urandom);
            end
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
